dcache_control: RTL and testbench
=================================

// Module: dcache_control
// PURPOSE
//  Control FSM for the 2-way set-associative L1 data cache. Sequences the per-way tag/valid/dirty
//  arrays, the per-set LRU array and the data arrays. Arrays read combinationally and write on clk.
//  Sits between the CPU data port and the physical-memory (pmem) port.
//  Decides hit/miss, dirty-victim writeback and line fill. Keeps hit/miss performance counters.
// PARAMETERS
//  CNT_WIDTH   32   width of hit_count / miss_count (saturating)
// PORTS
//  clk          in   1          clock; all state updates on posedge
//  rst          in   1          synchronous, active-high reset
//  mem_read     in   1          CPU read request; held until mem_resp
//  mem_write    in   1          CPU write request; held until mem_resp; never with mem_read
//  mem_resp     out  1          CPU request complete (1-cycle pulse)
//  hit          in   2          per-way tag match AND valid, from datapath
//  valid        in   2          per-way valid bits of indexed set
//  dirty        in   2          per-way dirty bits of indexed set
//  lru          in   1          LRU array output: way to evict next
//  pmem_read    out  1          line-fill request to memory
//  pmem_write   out  1          line-writeback request to memory
//  pmem_resp    in   1          memory transaction complete (1-cycle pulse)
//  addr_sel     out  1          0: pmem addr = CPU tag+index; 1: victim tag+index (writeback)
//  data_sel     out  1          0: data array input from CPU (write hit); 1: from pmem (fill)
//  data_we      out  2          per-way data array write enable
//  load_tag     out  2          per-way tag+valid array load (valid_in = 1)
//  load_dirty   out  2          per-way dirty array load
//  dirty_in     out  1          value written to dirty array
//  load_lru     out  1          LRU array load
//  lru_in       out  1          value written to LRU array
//  hit_count    out  CNT_WIDTH  CPU requests served without a miss
//  miss_count   out  CNT_WIDTH  CPU requests that missed
// BEHAVIOUR
//  Reset: state=IDLE; all control outputs 0; counters 0; victim reg 0; refill flag 0.
//  All control outputs are combinational from state and inputs; default 0.
//  IDLE, req = mem_read|mem_write:
//   - |hit: mem_resp=1, load_lru=1, lru_in=~hit_way (other way becomes LRU).
//     Write: data_we[hit_way]=1, data_sel=0, load_dirty[hit_way]=1, dirty_in=1.
//     hit_count++ unless refill flag set; refill flag cleared. Stay IDLE. Latency = 1 cycle.
//   - miss: victim<=lru; miss_count++.
//     valid[lru]&dirty[lru] -> WRITEBACK; else -> FILL.
//   - hit==2'b11 is illegal; way 0 wins.
//  WRITEBACK: pmem_write=1, addr_sel=1 (victim = registered way). pmem_resp -> FILL.
//  FILL: pmem_read=1, addr_sel=0.
//   - On pmem_resp: data_we[victim]=1, data_sel=1, load_tag[victim]=1,
//     load_dirty[victim]=1, dirty_in=0; set refill flag; -> IDLE.
//   - Next cycle in IDLE re-hits and completes the request; no second count.
//  pmem_read/pmem_write held high continuously until pmem_resp; never both high.
//  Request dropped while in WRITEBACK/FILL: memory transaction still completes, FSM returns to IDLE.
//   No mem_resp if req is low in IDLE; refill flag cleared on next IDLE cycle with req low.
//  pmem_resp outside WRITEBACK/FILL: ignored.
//  Counters saturate at all-ones.
//  Reset mid-transaction: IDLE immediately, pmem request dropped, no array writes that cycle.
// TESTING
//  1 Read hit way1 (hit=10, lru=1): mem_resp same cycle; load_lru=1, lru_in=0; hit_count=1.
//  2 Write hit way0: data_we=01, load_dirty=01, dirty_in=1, mem_resp; no pmem activity.
//  3 Clean miss, lru=0: FILL, pmem_read high 5 cycles until pmem_resp.
//    Then load_tag=01, data_we=01, dirty_in=0. Re-hit -> mem_resp.
//    Result: miss_count=1, hit_count=0.
//  4 Dirty miss, lru=1, dirty=10, valid=10: WRITEBACK with pmem_write, addr_sel=1.
//    pmem_resp -> FILL with pmem_read; fill writes way1; mem_resp total after writeback+fill+1.
//  5 rst asserted mid-FILL with pmem_read high: next cycle pmem_read=0, state IDLE, counters 0.
//  6 Preload hit_count=2^CNT_WIDTH-1 (CNT_WIDTH=4, 16 hits): count stays 15.

Source files
------------

// File: rtl/dcache_control.sv
// Control FSM for a 2-way set-associative L1 data cache: hit/miss decision,
// dirty-victim writeback, line fill and saturating hit/miss counters.
module dcache_control #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic [1:0]           hit,
    input  logic [1:0]           valid,
    input  logic [1:0]           dirty,
    input  logic                 lru,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    output logic                 addr_sel,
    output logic                 data_sel,
    output logic [1:0]           data_we,
    output logic [1:0]           load_tag,
    output logic [1:0]           load_dirty,
    output logic                 dirty_in,
    output logic                 load_lru,
    output logic                 lru_in,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    state_t state;
    logic   victim;
    logic   refill;
    logic   req;
    logic   any_hit;
    logic   hit_way;

    assign req     = mem_read | mem_write;
    assign any_hit = |hit;
    // way 0 takes priority if both ways ever report a hit
    assign hit_way = hit[0] ? 1'b0 : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            victim     <= 1'b0;
            refill     <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!req) begin
                        refill <= 1'b0;
                    end else if (any_hit) begin
                        // the re-hit after a fill was already counted as a miss
                        if (!refill && hit_count != '1)
                            hit_count <= hit_count + 1'b1;
                        refill <= 1'b0;
                    end else begin
                        victim <= lru;
                        if (miss_count != '1)
                            miss_count <= miss_count + 1'b1;
                        state <= (valid[lru] && dirty[lru]) ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp)
                        state <= FILL;
                end
                FILL: begin
                    if (pmem_resp) begin
                        refill <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp   = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        addr_sel   = 1'b0;
        data_sel   = 1'b0;
        data_we    = 2'b00;
        load_tag   = 2'b00;
        load_dirty = 2'b00;
        dirty_in   = 1'b0;
        load_lru   = 1'b0;
        lru_in     = 1'b0;
        // reset suppresses every request and array write in the same cycle
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req && any_hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (mem_write) begin
                            data_we[hit_way]    = 1'b1;
                            load_dirty[hit_way] = 1'b1;
                            dirty_in            = 1'b1;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write = 1'b1;
                    addr_sel   = 1'b1;
                end
                FILL: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        data_sel           = 1'b1;
                        data_we[victim]    = 1'b1;
                        load_tag[victim]   = 1'b1;
                        load_dirty[victim] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_control.sv
// Directed bench for dcache_control: hits, clean/dirty misses, reset mid-fill,
// stray pmem_resp and counter saturation (CNT_WIDTH=4).
module tb_dcache_control;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_read, mem_write, mem_resp;
    logic [1:0]    hit, valid, dirty;
    logic          lru;
    logic          pmem_read, pmem_write, pmem_resp;
    logic          addr_sel, data_sel;
    logic [1:0]    data_we, load_tag, load_dirty;
    logic          dirty_in, load_lru, lru_in;
    logic [CW-1:0] hit_count, miss_count;

    int total = 0;
    int bad   = 0;

    dcache_control #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit(hit), .valid(valid), .dirty(dirty), .lru(lru),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .addr_sel(addr_sel), .data_sel(data_sel), .data_we(data_we),
        .load_tag(load_tag), .load_dirty(load_dirty), .dirty_in(dirty_in),
        .load_lru(load_lru), .lru_in(lru_in),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mem_read = 0; mem_write = 0; hit = 0; valid = 0; dirty = 0;
        lru = 0; pmem_resp = 0;
        tick(); tick();
        chk("rst_hit_count", 32'(hit_count), 0);
        chk("rst_miss_count", 32'(miss_count), 0);
        chk("rst_pmem", {pmem_read, pmem_write, mem_resp, load_lru}, 0);
        rst = 1'b0; #1;
        chk("idle_outputs", {data_we, load_tag, load_dirty, addr_sel, data_sel}, 0);

        // 1: read hit on way 1
        mem_read = 1; hit = 2'b10; lru = 1; valid = 2'b11; #1;
        chk("t1_mem_resp", mem_resp, 1);
        chk("t1_lru", {load_lru, lru_in}, 2'b10);
        chk("t1_no_write", {data_we, load_dirty}, 0);
        tick(); mem_read = 0; hit = 0; #1;
        chk("t1_hit_count", 32'(hit_count), 1);
        chk("t1_mem_resp_low", mem_resp, 0);

        // 2: write hit on way 0
        mem_write = 1; hit = 2'b01; lru = 0; #1;
        chk("t2_data_we", data_we, 2'b01);
        chk("t2_load_dirty", load_dirty, 2'b01);
        chk("t2_dirty_sel", {dirty_in, data_sel, mem_resp}, 3'b101);
        chk("t2_lru", {load_lru, lru_in}, 2'b11);
        chk("t2_no_pmem", {pmem_read, pmem_write}, 0);
        tick(); mem_write = 0; hit = 0; #1;
        chk("t2_hit_count", 32'(hit_count), 2);

        // 3: clean miss, victim way 0
        do_reset();
        mem_read = 1; hit = 2'b00; lru = 0; valid = 2'b01; dirty = 2'b00; #1;
        chk("t3_no_resp_on_miss", mem_resp, 0);
        tick();
        chk("t3_miss_count", 32'(miss_count), 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_pmem_read_held", {pmem_read, pmem_write, addr_sel}, 3'b100);
            chk("t3_no_early_write", {data_we, load_tag}, 0);
            tick();
        end
        pmem_resp = 1; #1;
        chk("t3_fill_read", pmem_read, 1);
        chk("t3_fill_tag", load_tag, 2'b01);
        chk("t3_fill_data", {data_we, load_dirty}, 4'b0101);
        chk("t3_fill_sel", {data_sel, dirty_in}, 2'b10);
        tick(); pmem_resp = 0; hit = 2'b01; #1;
        chk("t3_rehit_resp", mem_resp, 1);
        chk("t3_rehit_pmem", pmem_read, 0);
        tick(); mem_read = 0; hit = 0; #1;
        chk("t3_hit_count", 32'(hit_count), 0);
        chk("t3_miss_count_final", 32'(miss_count), 1);

        // 4: dirty miss, victim way 1 (lru changes after the decision)
        mem_read = 1; lru = 1; valid = 2'b10; dirty = 2'b10; #1;
        tick(); lru = 0; #1;
        chk("t4_wb", {pmem_write, addr_sel, pmem_read}, 3'b110);
        tick();
        chk("t4_wb_held", {pmem_write, addr_sel}, 2'b11);
        pmem_resp = 1; #1;
        chk("t4_wb_no_write", {data_we, load_tag}, 0);
        tick(); pmem_resp = 0; #1;
        chk("t4_fill", {pmem_read, pmem_write, addr_sel}, 3'b100);
        pmem_resp = 1; #1;
        chk("t4_fill_way1", {load_tag, data_we, load_dirty}, 6'b101010);
        tick(); pmem_resp = 0; hit = 2'b10; #1;
        chk("t4_rehit", {mem_resp, load_lru, lru_in}, 3'b110);
        tick(); mem_read = 0; hit = 0; #1;
        chk("t4_miss_count", 32'(miss_count), 2);
        chk("t4_hit_count", 32'(hit_count), 0);

        // stray pmem_resp in IDLE is ignored
        pmem_resp = 1; #1;
        chk("stray_resp", {pmem_read, pmem_write, data_we, load_tag, mem_resp}, 0);
        tick(); pmem_resp = 0; mem_read = 1; hit = 2'b01; #1;
        chk("stray_still_idle", mem_resp, 1);
        tick(); mem_read = 0; hit = 0; #1;
        chk("stray_hit_count", 32'(hit_count), 1);

        // 5: reset in the middle of a fill
        mem_read = 1; lru = 0; valid = 2'b00; dirty = 2'b00; #1;
        tick();
        chk("t5_fill", pmem_read, 1);
        rst = 1; pmem_resp = 1; #1;
        chk("t5_rst_no_writes", {pmem_read, data_we, load_tag, load_dirty}, 0);
        tick(); rst = 0; pmem_resp = 0; mem_read = 0; #1;
        chk("t5_pmem_dropped", {pmem_read, pmem_write}, 0);
        chk("t5_counters", {hit_count, miss_count}, 0);
        mem_read = 1; hit = 2'b01; #1;
        chk("t5_idle_hit", mem_resp, 1);
        tick();
        chk("t5_hit_counted", 32'(hit_count), 1);

        // 6: saturation of the hit counter
        for (int i = 0; i < 16; i++) tick();
        chk("t6_saturated", 32'(hit_count), 15);
        tick();
        chk("t6_stays", 32'(hit_count), 15);
        chk("t6_miss_untouched", 32'(miss_count), 0);
        mem_read = 0; hit = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
